// File: rtl/y86_mem_loader.sv
// rtl/y86_mem_loader.sv - boot loader and byte RAM serving the y86 core bus; optional MEM_WRITE_PROTECT_EN
module y86_mem_loader #(
  parameter int         ADDR_W     = 12,
  parameter int         RST_CYCLES = 2,
  parameter logic [7:0] HALT_OPC   = 8'hF4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              core_rst,
  input  logic [31:0]       bus_A,
  input  logic              bus_RE,
  input  logic              bus_WE,
  input  logic [31:0]       bus_out,
  output logic [31:0]       bus_in,
  input  logic [7:0]        current_opcode,
  output logic              halted,
  output logic [ADDR_W:0]   load_count,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {LOAD, BOOT, RUN, HALT} state_t;

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] addr [4];
  logic [CNT_W-1:0]  boot_cnt;
  logic              halt_arm;
  logic              ld_xfer, ld_done, core_phase, out_of_range;
  logic              wr_blocked, wr_en, access_err;

  assign ld_xfer      = (state == LOAD) && ld_valid;
  assign ld_done      = ld_xfer && (ld_last || load_count == (ADDR_W+1)'(DEPTH-1));
  assign core_phase   = (state == RUN) || (state == HALT);
  assign out_of_range = bus_A[31:ADDR_W] != '0;

  // Byte lanes of a 32-bit access wrap around the top of the RAM.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      addr[k] = bus_A[ADDR_W-1:0] + ADDR_W'(k);
    end
  end

`ifdef MEM_WRITE_PROTECT_EN
  always_comb begin
    wr_blocked = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ({1'b0, addr[k]} < load_count) wr_blocked = 1'b1;
    end
  end
`else
  assign wr_blocked = 1'b0;
`endif

  assign wr_en      = (state == RUN) && bus_WE && !wr_blocked;
  assign access_err = (core_phase && (bus_RE || bus_WE) && out_of_range) ||
                      ((state == RUN) && bus_WE && wr_blocked);

  assign bus_in = (core_phase && bus_RE) ?
                  {mem[addr[3]], mem[addr[2]], mem[addr[1]], mem[addr[0]]} : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    core_rst  = 1'b0;
    halted    = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        core_rst = 1'b1;
        if (ld_done) state_nxt = BOOT;
      end
      BOOT: begin
        core_rst = 1'b1;
        if (boot_cnt == CNT_W'(RST_CYCLES-1)) state_nxt = RUN;
      end
      RUN: begin
        if (halt_arm && current_opcode == HALT_OPC) state_nxt = HALT;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // halt_arm waits for the first real fetch so stale IR contents cannot halt us.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_count <= '0;
      boot_cnt   <= '0;
      halt_arm   <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (ld_xfer) load_count <= load_count + 1'b1;
      if (state == BOOT) boot_cnt <= boot_cnt + 1'b1;
      else               boot_cnt <= '0;
      if (state == RUN && bus_RE) halt_arm <= 1'b1;
      if (access_err) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_xfer) begin
      mem[load_count[ADDR_W-1:0]] <= ld_data;
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        mem[addr[k]] <= bus_out[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_y86_mem_loader.sv
// tb/tb_y86_mem_loader.sv - randomized self-checking bench for y86_mem_loader
module tb_y86_mem_loader;
  localparam int ADDR_W     = 12;
  localparam int DEPTH      = 4096;
  localparam int RST_CYCLES = 2;

  logic        clk, rst;
  logic        ld_valid, ld_last, ld_ready, core_rst;
  logic [7:0]  ld_data, current_opcode;
  logic [31:0] bus_A, bus_out, bus_in;
  logic        bus_RE, bus_WE, halted, err;
  logic [ADDR_W:0] load_count;

  y86_mem_loader #(.ADDR_W(ADDR_W), .RST_CYCLES(RST_CYCLES), .HALT_OPC(8'hF4)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .core_rst(core_rst), .bus_A(bus_A), .bus_RE(bus_RE),
    .bus_WE(bus_WE), .bus_out(bus_out), .bus_in(bus_in), .current_opcode(current_opcode),
    .halted(halted), .load_count(load_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [DEPTH];
  logic [7:0] prog [DEPTH];
  int exp_count;
  bit exp_halt;
  bit exp_err;

  function automatic logic [31:0] exp_read(input int a);
    int b = a % DEPTH;
    return {mm[(b+3)%DEPTH], mm[(b+2)%DEPTH], mm[(b+1)%DEPTH], mm[b]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h0;
    bus_RE = 1'b0; bus_WE = 1'b0; bus_A = 32'h0; bus_out = 32'h0; current_opcode = 8'h0;
    repeat (2) tick;
    rst = 1'b1;
    exp_count = 0; exp_halt = 1'b0; exp_err = 1'b0;
  endtask

  task automatic core_write(input int a, input logic [31:0] d);
    bit blocked;
    bus_A = a; bus_out = d; bus_WE = 1'b1;
    tick;
    bus_WE = 1'b0;
    blocked = exp_halt;
`ifdef MEM_WRITE_PROTECT_EN
    for (int k = 0; k < 4; k++) if (((a + k) % DEPTH) < exp_count && !exp_halt) begin
      blocked = 1'b1; exp_err = 1'b1;
    end
`endif
    if (!blocked) for (int k = 0; k < 4; k++) mm[(a + k) % DEPTH] = d[8*k +: 8];
  endtask

  task automatic load_prog(input int n, input bit use_last);
    int nb;
    bus_RE = 1'b1; bus_A = 32'h0;
    #1;
    checks++;
    if (bus_in !== 32'h0 || ld_ready !== 1'b1) begin
      errors++; $display("FAIL load_idle bus_in=%h ld_ready=%b want 0/1", bus_in, ld_ready);
    end
    bus_RE = 1'b0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) tick;
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = use_last && (i == n - 1);
      tick;
      mm[exp_count] = prog[i];
      exp_count++;
      ld_valid = 1'b0; ld_last = 1'b0;
    end
    checks++;
    if (load_count !== (ADDR_W+1)'(exp_count) || ld_ready !== 1'b0) begin
      errors++; $display("FAIL load_done load_count=%0d ld_ready=%b want %0d/0", load_count, ld_ready, exp_count);
    end
    nb = 0;
    while (core_rst === 1'b1 && nb < 20) begin
      nb++; tick;
    end
    checks++;
    if (nb != RST_CYCLES) begin
      errors++; $display("FAIL boot_len got %0d cycles want %0d", nb, RST_CYCLES);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h0;
    bus_RE = 1'b0; bus_WE = 1'b0; bus_A = 32'h0; bus_out = 32'h0; current_opcode = 8'h0;
    #3;
    checks++;
    if (ld_ready !== 1'b1 || core_rst !== 1'b1 || halted !== 1'b0 || load_count !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals ld_ready=%b core_rst=%b halted=%b load_count=%0d err=%b want 1/1/0/0/0",
               ld_ready, core_rst, halted, load_count, err);
    end
    do_reset;
  endtask

  task automatic test_full_load;
    for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom);
    prog[3] = 8'h00;
    load_prog(DEPTH, 1'b0);
    bus_A = 32'h0000_0FFD; bus_RE = 1'b1;
    #1;
    checks++;
    if (bus_in !== exp_read(32'hFFD)) begin
      errors++; $display("FAIL full_load_read got %h want %h", bus_in, exp_read(32'hFFD));
    end
    tick;
    bus_RE = 1'b0;
  endtask

  task automatic test_small_load;
    do_reset;
    prog[0] = 8'h01; prog[1] = 8'hC3; prog[2] = 8'hF4;
    load_prog(3, 1'b1);
    bus_A = 32'h0; bus_RE = 1'b1;
    #1;
    checks++;
    if (bus_in !== 32'h00F4C301) begin
      errors++; $display("FAIL small_read got %h want 00f4c301", bus_in);
    end
    tick;
    bus_RE = 1'b0;
    #1;
    checks++;
    if (bus_in !== 32'h0) begin
      errors++; $display("FAIL re_low got %h want 0", bus_in);
    end
  endtask

  task automatic test_rw;
    int a, w;
    logic [31:0] d;
    do_reset;
    for (int i = 0; i < 8; i++) prog[i] = 8'($urandom);
    load_prog(8, 1'b1);
    core_write(32'h10, 32'hDEADBEEF);
    bus_A = 32'h10; bus_RE = 1'b1;
    #1;
    checks++;
    if (bus_in !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rw_10 got %h want deadbeef", bus_in);
    end
    bus_A = 32'h12;
    #1;
    checks++;
    if (bus_in !== {mm[16'h15], mm[16'h14], 8'hDE, 8'hAD}) begin
      errors++; $display("FAIL rw_12 got %h want %h", bus_in, {mm[16'h15], mm[16'h14], 8'hDE, 8'hAD});
    end
    tick;
    for (int i = 0; i < 30; i++) begin
      a = 32'h100 + $urandom_range(0, 31);
      w = 32'h100 + $urandom_range(0, 31);
      d = $urandom;
      bus_A = a; bus_RE = 1'b1;
      #1;
      checks++;
      if (bus_in !== exp_read(a)) begin
        errors++; $display("FAIL rand_read[%0d] a=%h got %h want %h", i, a, bus_in, exp_read(a));
      end
      bus_RE = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        bus_RE = 1'b1;
        bus_A = w;
        #1;
        checks++;
        if (bus_in !== exp_read(w)) begin
          errors++; $display("FAIL rmw_preread[%0d] a=%h got %h want %h", i, w, bus_in, exp_read(w));
        end
      end
      core_write(w, d);
      bus_RE = 1'b0;
    end
    checks++;
    if (err !== exp_err) begin
      errors++; $display("FAIL rw_err got %b want %b", err, exp_err);
    end
  endtask

  task automatic test_wrap;
    core_write(32'hFFE, 32'h11223344);
    bus_A = 32'hFFE; bus_RE = 1'b1;
    #1;
    checks++;
    if (bus_in !== exp_read(32'hFFE)) begin
      errors++; $display("FAIL wrap_read got %h want %h", bus_in, exp_read(32'hFFE));
    end
    bus_A = 32'hFFF;
    #1;
    checks++;
    if (bus_in !== exp_read(32'hFFF)) begin
      errors++; $display("FAIL wrap_read_fff got %h want %h", bus_in, exp_read(32'hFFF));
    end
    tick;
    bus_RE = 1'b0;
    checks++;
    if (err !== exp_err) begin
      errors++; $display("FAIL wrap_err got %b want %b", err, exp_err);
    end
  endtask

  task automatic test_out_of_range;
    bus_A = 32'h0000_1000; bus_RE = 1'b1;
    #1;
    checks++;
    if (bus_in !== exp_read(0) || err !== 1'b0) begin
      errors++; $display("FAIL oor_read got %h err=%b want %h err=0", bus_in, err, exp_read(0));
    end
    tick;
    bus_RE = 1'b0; bus_A = 32'h0;
    repeat (3) tick;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL oor_sticky err=%b want 1", err);
    end
  endtask

  task automatic test_halt;
    logic [31:0] v1;
    do_reset;
    for (int i = 0; i < 4; i++) prog[i] = 8'($urandom);
    load_prog(4, 1'b1);
    current_opcode = 8'hF4;
    repeat (3) tick;
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL halt_unarmed halted=%b want 0", halted);
    end
    v1 = $urandom;
    core_write(32'h20, v1);
    bus_A = 32'h20; bus_RE = 1'b1;
    #1;
    checks++;
    if (bus_in !== v1) begin
      errors++; $display("FAIL halt_preread got %h want %h", bus_in, v1);
    end
    tick;
    bus_RE = 1'b0;
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL halt_arm_edge halted=%b want 0", halted);
    end
    tick;
    exp_halt = 1'b1;
    checks++;
    if (halted !== 1'b1 || core_rst !== 1'b0) begin
      errors++; $display("FAIL halt_enter halted=%b core_rst=%b want 1/0", halted, core_rst);
    end
    current_opcode = 8'h00;
    core_write(32'h20, ~v1);
    bus_A = 32'h20; bus_RE = 1'b1;
    #1;
    checks++;
    if (bus_in !== v1 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_write_drop got %h halted=%b want %h/1", bus_in, halted, v1);
    end
    tick;
    bus_RE = 1'b0;
  endtask

  task automatic test_midrun_reset;
    do_reset;
    for (int i = 0; i < 5; i++) prog[i] = 8'($urandom);
    load_prog(5, 1'b1);
    bus_A = 32'h0001_0004; bus_RE = 1'b1;
    tick;
    bus_RE = 1'b0;
    checks++;
    if (err !== 1'b1 || core_rst !== 1'b0) begin
      errors++; $display("FAIL pre_rst err=%b core_rst=%b want 1/0", err, core_rst);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ld_ready !== 1'b1 || core_rst !== 1'b1 || load_count !== '0 || halted !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL midrun_rst[%0d] ld_ready=%b core_rst=%b load_count=%0d halted=%b err=%b want 1/1/0/0/0",
                 i, ld_ready, core_rst, load_count, halted, err);
      end
      tick;
    end
    rst = 1'b1;
    exp_count = 0; exp_halt = 1'b0; exp_err = 1'b0;
    tick;
    checks++;
    if (ld_ready !== 1'b1 || core_rst !== 1'b1 || load_count !== '0) begin
      errors++; $display("FAIL post_rst ld_ready=%b core_rst=%b load_count=%0d want 1/1/0", ld_ready, core_rst, load_count);
    end
  endtask

  initial begin
    test_reset;
    test_full_load;
    test_small_load;
    test_rw;
    test_wrap;
    test_out_of_range;
    test_halt;
    test_midrun_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
